// File: rtl/blockexp_norm_ctrl.sv
// blockexp_norm_ctrl: block-floating-point sequencer.
// Collects BLOCK_LEN complex 16-bit samples, tracks the largest per-sample
// exponent, then drains the block as 10-bit I/Q sharing that one exponent.
// Optional feature macro: BLOCKEXP_ROUND_EN (round-half-up plus saturation
// before slicing); when undefined, outputs are plain arithmetic-shift truncation.
// Ports:
//   clk, rst_b               clock, asynchronous active-low reset
//   start, abort             block start pulse (IDLE only), discard-and-return
//   in_valid/in_ready        input handshake, in_i/in_q 16-bit two's complement
//   out_valid/out_ready      output handshake, out_i/out_q 10-bit two's complement
//   out_exp, out_last        shared block exponent, final-sample marker
//   busy                     state is not IDLE
module blockexp_norm_ctrl #(
  parameter int unsigned BLOCK_LEN = 16,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_i,
  input  logic [15:0] in_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_i,
  output logic [9:0]  out_q,
  output logic [3:0]  out_exp,
  output logic        out_last,
  output logic        busy
);

  localparam int unsigned DW = 16;
  localparam int unsigned OW = 10;
  localparam int unsigned EW = 3;
  localparam int unsigned SW = DW + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*DW-1:0] mem [BLOCK_LEN];
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic [EW-1:0]    run_max, blk_exp;
  logic [EW-1:0]    e_i, e_q, samp_e, acc_max;
  logic             accept, xfer;
  logic signed [DW-1:0] rd_i, rd_q;

  // Exponent = 1 + highest bit pair (k+10, k+9) that differs; 0 if the
  // value already fits in 10 bits.
  function automatic logic [EW-1:0] comp_exp(input logic [DW-1:0] x);
    logic [EW-1:0] e;
    e = '0;
    for (int k = 0; k < 6; k++) begin
      if (x[k+10] ^ x[k+9]) e = EW'(k + 1);
    end
    return e;
  endfunction

`ifdef BLOCKEXP_ROUND_EN
  // Round half up in 17-bit arithmetic, shift, then saturate to 10 bits.
  function automatic logic [OW-1:0] scale(input logic signed [DW-1:0] x,
                                          input logic [EW-1:0] e);
    logic signed [SW-1:0] bias, sum, sh;
    bias = (e == '0) ? '0 : (SW'(1) << (e - EW'(1)));
    sum  = {x[DW-1], x} + bias;
    sh   = sum >>> e;
    if ((&sh[SW-1:OW-1]) || !(|sh[SW-1:OW-1])) return sh[OW-1:0];
    else if (sh[SW-1]) return {1'b1, {(OW-1){1'b0}}};
    else return {1'b0, {(OW-1){1'b1}}};
  endfunction
`else
  // Plain arithmetic shift; the exponent guarantees the result fits.
  function automatic logic [OW-1:0] scale(input logic signed [DW-1:0] x,
                                          input logic [EW-1:0] e);
    return OW'(x >>> e);
  endfunction
`endif

  // Running maximum including the sample currently on the input.
  always_comb begin
    e_i     = comp_exp(in_i);
    e_q     = comp_exp(in_q);
    samp_e  = (e_i > e_q) ? e_i : e_q;
    acc_max = (samp_e > run_max) ? samp_e : run_max;
  end

  assign accept = (state == FILL) && in_valid;
  assign xfer   = (state == DRAIN) && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake/status decode; abort wins over everything.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (accept && (wr_cnt == LAST_IDX)) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (xfer && (rd_cnt == LAST_IDX)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Counters, running exponent and sample buffer.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      run_max <= '0;
      blk_exp <= '0;
      for (int n = 0; n < int'(BLOCK_LEN); n++) mem[n] <= '0;
    end else if (abort) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      run_max <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wr_cnt  <= '0;
            run_max <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            mem[wr_cnt] <= {in_i, in_q};
            run_max     <= acc_max;
            if (wr_cnt == LAST_IDX) begin
              wr_cnt  <= '0;
              rd_cnt  <= '0;
              blk_exp <= acc_max;
            end else begin
              wr_cnt <= wr_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (xfer) rd_cnt <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Output mux straight from buffer registers; data is zero outside DRAIN.
  assign rd_i = mem[rd_cnt][2*DW-1:DW];
  assign rd_q = mem[rd_cnt][DW-1:0];

  always_comb begin
    out_i    = '0;
    out_q    = '0;
    out_last = 1'b0;
    out_exp  = {1'b0, blk_exp};
    if (state == DRAIN) begin
      out_i    = scale(rd_i, blk_exp);
      out_q    = scale(rd_q, blk_exp);
      out_last = (rd_cnt == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_blockexp_norm_ctrl.sv
// Directed bench for blockexp_norm_ctrl with hand-computed expectations.
module tb_blockexp_norm_ctrl;

  logic        clk, rst_b, start, abort, in_valid, in_ready;
  logic [15:0] in_i, in_q;
  logic        out_valid, out_ready, out_last, busy;
  logic [9:0]  out_i, out_q;
  logic [3:0]  out_exp;

  int errors = 0;
  int checks = 0;
  int di[16], dq[16], ei[16], eq[16];
  int eexp;

  blockexp_norm_ctrl #(.BLOCK_LEN(16), .CNT_W(4)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
    .out_exp(out_exp), .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic fill_all(input int i, input int q, input int oi, input int oq);
    for (int s = 0; s < 16; s++) begin
      di[s] = i; dq[s] = q; ei[s] = oi; eq[s] = oq;
    end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);
  endtask

  // Offers n samples back to back; leaves time at the negedge after the last.
  task automatic send(input int n);
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      chk("fill_out_valid", out_valid, 0);
      chk("fill_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_i = 16'(di[s]);
      in_q = 16'(dq[s]);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // pat=0: out_ready held high; pat=1: out_ready cycles 1,0,0,1.
  task automatic drain(input int pat);
    int idx = 0;
    int cyc = 0;
    logic rdy;
    while (idx < 16 && cyc < 200) begin
      rdy = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      out_ready = rdy;
      chk("drain_valid", out_valid, 1);
      chk($sformatf("out_i[%0d]", idx), $signed(out_i), ei[idx]);
      chk($sformatf("out_q[%0d]", idx), $signed(out_q), eq[idx]);
      chk("out_exp", out_exp, eexp);
      chk($sformatf("out_last[%0d]", idx), out_last, (idx == 15) ? 1 : 0);
      if (rdy) idx++;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain_transfers", idx, 16);
    chk("post_drain_valid", out_valid, 0);
    chk("post_drain_busy", busy, 0);
  endtask

  initial begin
    rst_b = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_i = '0; in_q = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_exp", out_exp, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    rst_b = 1'b1;

    // Reset in the middle of a fill, then a full block from scratch.
    fill_all(100, -100, 25, -25);
    di[5] = 1024; ei[5] = 256; eexp = 2;
    do_start();
    send(7);
    rst_b = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_exp", out_exp, 0);
    chk("midrst_out_i", out_i, 0);
    @(negedge clk);
    rst_b = 1'b1;
    do_start();
    send(16);
    drain(0);

    // Half-LSB values: truncation vs rounding, drained under backpressure.
`ifdef BLOCKEXP_ROUND_EN
    fill_all(102, -102, 26, -25);
`else
    fill_all(102, -102, 25, -26);
`endif
    di[5] = 1024; ei[5] = 256; eq[5] = eq[0]; eexp = 2;
    do_start();
    send(16);
    drain(1);

    // Full-scale sample: exponent 6, positive end saturates when rounding.
    fill_all(0, 0, 0, 0);
    di[0] = 32767; dq[0] = -32768; ei[0] = 511; eq[0] = -512; eexp = 6;
    do_start();
    send(16);
    drain(0);

    // abort together with start during DRAIN.
    fill_all(1000, 0, 500, 0);
    eexp = 1;
    do_start();
    send(16);
    out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0; out_ready = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    @(negedge clk);
    chk("abort_start_ignored", busy, 0);

    // All-zero block.
    fill_all(0, 0, 0, 0);
    eexp = 0;
    do_start();
    send(16);
    drain(0);

    // Constant I=1000 block.
    fill_all(1000, 0, 500, 0);
    eexp = 1;
    do_start();
    send(16);
    drain(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
